// File: rtl/cc_branch_unit.sv
// cc_branch_unit: multi-context NZP condition-code register and branch resolver.
// Classifies ALU results into per-context one-hot NZP state, resolves branches
// against a selected context (optionally bypassing a same-cycle write), drives
// the PC-select control and keeps a saturating count of taken branches.
//
// Ports:
//   clka          in   1       clock, rising edge
//   reset_in      in   1       asynchronous active-low reset
//   alu_result_in in   DATA_W  ALU result to classify
//   we_reg_in     in   1       CC write enable
//   wr_ctx_in     in   CTX_W   context written / cleared
//   ctx_clr_in    in   1       return wr_ctx_in context to IDLE (wins over write)
//   br_in         in   1       branch present
//   br_ctx_in     in   CTX_W   context tested by the branch
//   n/z/p_dec_in  in   1       decoded branch condition bits
//   rd_ctx_in     in   CTX_W   context shown on state_out
//   pc_ctl_0_out  out  1       1 = take branch
//   state_out     out  3       {N,Z,P} of rd_ctx_in (stored state)
//   taken_cnt_out out  CNT_W   saturating taken-branch count
module cc_branch_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_CTX = 4,
    parameter int unsigned CTX_W   = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned REG_OUT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clka,
    input  logic              reset_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              we_reg_in,
    input  logic [CTX_W-1:0]  wr_ctx_in,
    input  logic              ctx_clr_in,
    input  logic              br_in,
    input  logic [CTX_W-1:0]  br_ctx_in,
    input  logic              n_dec_in,
    input  logic              z_dec_in,
    input  logic              p_dec_in,
    input  logic [CTX_W-1:0]  rd_ctx_in,
    output logic              pc_ctl_0_out,
    output logic [2:0]        state_out,
    output logic [CNT_W-1:0]  taken_cnt_out
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_N    = 3'b100,
        ST_Z    = 3'b010,
        ST_P    = 3'b001
    } cc_state_t;

    cc_state_t        r_cc     [NUM_CTX];
    cc_state_t        w_cc_nxt [NUM_CTX];
    cc_state_t        w_class;
    cc_state_t        w_br_cc;
    cc_state_t        w_rd_cc;
    logic             w_wr_valid;
    logic             w_take;
    logic             r_pc;
    logic [CNT_W-1:0] r_cnt;

    // Classification of the incoming ALU result
    always_comb begin
        w_class = ST_P;
        if (alu_result_in[DATA_W-1])
            w_class = ST_N;
        else if (alu_result_in == '0)
            w_class = ST_Z;
    end

    assign w_wr_valid = (32'(wr_ctx_in) < NUM_CTX);

    // Next-state for every context: clear beats write, otherwise hold
    always_comb begin
        for (int unsigned i = 0; i < NUM_CTX; i++) begin
            w_cc_nxt[i] = r_cc[i];
            if (CTX_W'(i) == wr_ctx_in) begin
                if (ctx_clr_in)
                    w_cc_nxt[i] = ST_IDLE;
                else if (we_reg_in)
                    w_cc_nxt[i] = w_class;
            end
        end
    end

    // Context state registers
    always_ff @(posedge clka or negedge reset_in) begin
        if (!reset_in) begin
            for (int unsigned i = 0; i < NUM_CTX; i++)
                r_cc[i] <= ST_IDLE;
        end else begin
            for (int unsigned i = 0; i < NUM_CTX; i++)
                r_cc[i] <= w_cc_nxt[i];
        end
    end

    // Branch-side lookup; out-of-range index reads as IDLE, optional write bypass
    always_comb begin
        w_br_cc = ST_IDLE;
        for (int unsigned i = 0; i < NUM_CTX; i++) begin
            if (CTX_W'(i) == br_ctx_in)
                w_br_cc = r_cc[i];
        end
        if ((BYPASS != 0) && w_wr_valid && (wr_ctx_in == br_ctx_in)) begin
            if (ctx_clr_in)
                w_br_cc = ST_IDLE;
            else if (we_reg_in)
                w_br_cc = w_class;
        end
    end

    // Read-side lookup, stored state only
    always_comb begin
        w_rd_cc = ST_IDLE;
        for (int unsigned i = 0; i < NUM_CTX; i++) begin
            if (CTX_W'(i) == rd_ctx_in)
                w_rd_cc = r_cc[i];
        end
    end

    assign w_take    = br_in & (|({n_dec_in, z_dec_in, p_dec_in} & w_br_cc));
    assign state_out = w_rd_cc;

    // Registered take and saturating taken counter
    always_ff @(posedge clka or negedge reset_in) begin
        if (!reset_in) begin
            r_pc  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_pc <= w_take;
            if (w_take && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign pc_ctl_0_out  = (REG_OUT != 0) ? r_pc : w_take;
    assign taken_cnt_out = r_cnt;

endmodule
